// File: rtl/i2s_transmitter.sv
// I2S transmitter: accepts one signed stereo pair per frame through valid/ready,
// double-buffers it and shifts it out MSB-first with internally generated bclk/lrclk.
module i2s_transmitter #(
    parameter int AUDIO_WIDTH = 24,
    parameter int SLOT_WIDTH  = 32,
    parameter int BCLK_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [AUDIO_WIDTH-1:0] sample_left,
    input  logic signed [AUDIO_WIDTH-1:0] sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int PAD_W      = SLOT_WIDTH - AUDIO_WIDTH;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_BITS - 2);

    logic [DIV_W-1:0]       r_div_cnt;
    logic                   r_bclk;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic                   r_lrclk;
    logic                   r_sdata;
    logic                   r_underrun;
    logic [AUDIO_WIDTH-1:0] r_hold_left;
    logic [AUDIO_WIDTH-1:0] r_hold_right;
    logic                   r_hold_full;

    logic                   w_tick;
    logic                   w_fall_tick;
    logic                   w_load;
    logic                   w_accept;
    logic [BIT_W-1:0]       w_bit_next;
    logic                   w_lrclk_next;
    logic [SLOT_WIDTH-1:0]  w_left_slot;
    logic [SLOT_WIDTH-1:0]  w_right_slot;
    logic [FRAME_BITS-1:0]  w_shift_src;

    // Zero-extend then shift left so the sample is MSB-aligned and padding is
    // always 0; this also works when there is no padding at all.
    assign w_left_slot  = SLOT_WIDTH'(r_hold_left)  << PAD_W;
    assign w_right_slot = SLOT_WIDTH'(r_hold_right) << PAD_W;

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_fall_tick = w_tick && r_bclk;
    assign w_load      = w_fall_tick && (r_bit_cnt == BIT_LAST);
    assign w_accept    = sample_valid && !r_hold_full;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_bit_next   = r_bit_cnt + 1'b1;
        w_shift_src  = r_shift;
        if (r_bit_cnt == BIT_LAST) begin
            w_bit_next = '0;
        end
        if (w_load) begin
            w_shift_src = r_hold_full ? {w_left_slot, w_right_slot} : '0;
        end
        w_lrclk_next = (w_bit_next >= LR_FIRST) && (w_bit_next <= LR_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_bit_cnt  <= BIT_LAST;
            r_shift    <= '0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_div_cnt  <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_underrun <= w_load && !r_hold_full;
            if (w_tick) begin
                r_bclk <= !r_bclk;
            end
            if (w_fall_tick) begin
                r_bit_cnt <= w_bit_next;
                r_lrclk   <= w_lrclk_next;
                r_sdata   <= w_shift_src[FRAME_BITS-1];
                r_shift   <= w_shift_src << 1;
            end
        end
    end

    // A load consumes a full buffer (no accept possible then); a pair accepted
    // on an empty-buffer load cycle is kept for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full  <= 1'b0;
            r_hold_left  <= '0;
            r_hold_right <= '0;
        end else begin
            if (w_load) begin
                r_hold_full <= w_accept;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
            if (w_accept) begin
                r_hold_left  <= sample_left;
                r_hold_right <= sample_right;
            end
        end
    end

    assign sample_ready = !r_hold_full;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: scoreboard of accepted pairs versus
// frames decoded from the serial stream, plus a BCLK_DIV=1 / no-padding instance.
module tb_i2s_transmitter;

    typedef struct {
        logic [63:0] data;
        logic [63:0] lr;
        logic        ur;
        int          load_cyc;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    logic        rst_b;
    logic [23:0] left_b;
    logic [23:0] right_b;
    logic        valid_b;
    logic        ready_b;
    logic        bclk_b;
    logic        lrclk_b;
    logic        sdata_b;
    logic        underrun_b;

    int          n_checks;
    int          n_pass;
    int          cyc;
    logic [63:0] exp_q[$];
    frame_t      obs_q[$];
    frame_t      cur;
    int          mon_bit;
    logic        mon_bclk_q;
    int          mon_ur_total;

    i2s_transmitter #(.AUDIO_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    i2s_transmitter #(.AUDIO_WIDTH(24), .SLOT_WIDTH(24), .BCLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b),
        .sample_left(left_b), .sample_right(right_b),
        .sample_valid(valid_b), .sample_ready(ready_b),
        .bclk(bclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .underrun(underrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Stream decoder: own bit counter, advanced on each observed bclk fall.
    always @(negedge clk) begin
        if (rst) begin
            mon_bit      = 63;
            mon_bclk_q   = 1'b0;
            mon_ur_total = 0;
            obs_q.delete();
            cur.data     = '0;
            cur.lr       = '0;
            cur.ur       = 1'b0;
            cur.load_cyc = 0;
        end else begin
            if (underrun === 1'b1) mon_ur_total++;
            if (mon_bclk_q === 1'b1 && bclk === 1'b0) begin
                mon_bit = (mon_bit == 63) ? 0 : mon_bit + 1;
                if (mon_bit == 0) begin
                    cur.ur       = underrun;
                    cur.load_cyc = cyc;
                end
                cur.data[63-mon_bit] = sdata;
                cur.lr[63-mon_bit]   = lrclk;
                if (mon_bit == 63) obs_q.push_back(cur);
            end
            mon_bclk_q = bclk;
        end
    end

    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    function automatic logic [63:0] lr_pattern();
        logic [63:0] v;
        for (int b = 0; b < 64; b++) v[63-b] = (b >= 31 && b <= 62);
        return v;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst          = 1'b1;
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input int budget,
                             output bit ok, output int acc_cyc);
        @(negedge clk);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        ok      = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (sample_ready === 1'b1) begin
                acc_cyc = cyc + 1;
                exp_q.push_back(frame_of(l, r));
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n * 600; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int rise_at;
        int fall_at;
        @(negedge clk);
        rst          = 1'b1;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bclk, lrclk, sdata, underrun} !== 4'b0000)
            $display("FAIL reset_outputs: got %b expected 0000", {bclk, lrclk, sdata, underrun});
        else n_pass++;
        n_checks++;
        if (sample_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", sample_ready);
        else n_pass++;
        rst     = 1'b0;
        rise_at = -1;
        fall_at = -1;
        for (int k = 1; k <= 20 && fall_at < 0; k++) begin
            @(negedge clk);
            if (rise_at < 0 && bclk === 1'b1) rise_at = k;
            else if (rise_at >= 0 && bclk === 1'b0) fall_at = k;
        end
        n_checks++;
        if (rise_at != 4) $display("FAIL first_bclk_rise: got %0d expected 4", rise_at);
        else n_pass++;
        n_checks++;
        if (fall_at != 8) $display("FAIL first_bclk_fall: got %0d expected 8", fall_at);
        else n_pass++;
    endtask

    task automatic test_single_pair();
        bit          ok;
        int          acc;
        frame_t      f;
        logic [63:0] exp;
        do_reset(3);
        send_pair(24'h800001, 24'h7FFFFE, 20, ok, acc);
        @(negedge clk);
        sample_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL single_accept: got not accepted expected accepted");
        else n_pass++;
        wait_frames(2, ok);
        n_checks++;
        if (!ok) $display("FAIL single_frames_timeout: got %0d frames expected 2", obs_q.size());
        else n_pass++;
        if (ok) begin
            f   = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (f.data !== exp) $display("FAIL single_data: got %h expected %h", f.data, exp);
            else n_pass++;
            n_checks++;
            if (f.lr !== lr_pattern()) $display("FAIL single_lrclk: got %h expected %h", f.lr, lr_pattern());
            else n_pass++;
            n_checks++;
            if (f.ur !== 1'b0) $display("FAIL single_no_underrun: got %b expected 0", f.ur);
            else n_pass++;
            f = obs_q.pop_front();
            n_checks++;
            if ({f.ur, f.data} !== {1'b1, 64'h0})
                $display("FAIL single_next_underrun: got ur=%b data=%h expected ur=1 data=0", f.ur, f.data);
            else n_pass++;
        end
    endtask

    task automatic test_underrun();
        bit     ok;
        frame_t f;
        do_reset(3);
        wait_frames(3, ok);
        n_checks++;
        if (!ok) $display("FAIL underrun_frames_timeout: got %0d frames expected 3", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && ok; i++) begin
            f = obs_q.pop_front();
            n_checks++;
            if ({f.ur, f.data} !== {1'b1, 64'h0})
                $display("FAIL underrun_frame%0d: got ur=%b data=%h expected ur=1 data=0", i, f.ur, f.data);
            else n_pass++;
            n_checks++;
            if (f.lr !== lr_pattern()) $display("FAIL underrun_lrclk%0d: got %h expected %h", i, f.lr, lr_pattern());
            else n_pass++;
        end
        n_checks++;
        if (mon_ur_total != 3) $display("FAIL underrun_pulse_count: got %0d expected 3", mon_ur_total);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          ok_a, ok_b, ok_c, ok;
        int          acc_a, acc_b, acc_c;
        int          start;
        frame_t      f;
        logic [63:0] exp;
        logic [23:0] lv[3];
        logic [23:0] rv[3];
        int          load_cyc[3];
        lv = '{24'h123456, 24'hFEDCBA, 24'hA5A5A5};
        rv = '{24'h654321, 24'h0F0F0F, 24'h5A5A5A};
        do_reset(3);
        start = cyc;
        send_pair(lv[0], rv[0], 20, ok_a, acc_a);
        @(negedge clk);
        n_checks++;
        if (!(ok_a && acc_a == start + 2 && sample_ready === 1'b0))
            $display("FAIL b2b_accept_a: got ok=%0d cyc=%0d ready=%b expected ok=1 cyc=%0d ready=0",
                     ok_a, acc_a, sample_ready, start + 2);
        else n_pass++;
        send_pair(lv[1], rv[1], 600, ok_b, acc_b);
        send_pair(lv[2], rv[2], 600, ok_c, acc_c);
        @(negedge clk);
        sample_valid = 1'b0;
        n_checks++;
        if (!(ok_b && ok_c)) $display("FAIL b2b_accept_bc: got ok_b=%0d ok_c=%0d expected 1 1", ok_b, ok_c);
        else n_pass++;
        wait_frames(4, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_frames_timeout: got %0d frames expected 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && ok; i++) begin
            f           = obs_q.pop_front();
            load_cyc[i] = f.load_cyc;
            exp         = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if ({f.ur, f.data} !== {1'b0, exp})
                $display("FAIL b2b_frame%0d: got ur=%b data=%h expected ur=0 data=%h", i, f.ur, f.data, exp);
            else n_pass++;
        end
        if (ok) begin
            n_checks++;
            if (acc_b != load_cyc[0] + 1) $display("FAIL b2b_accept_b_cycle: got %0d expected %0d", acc_b, load_cyc[0] + 1);
            else n_pass++;
            n_checks++;
            if (acc_c != load_cyc[1] + 1) $display("FAIL b2b_accept_c_cycle: got %0d expected %0d", acc_c, load_cyc[1] + 1);
            else n_pass++;
            f = obs_q.pop_front();
            n_checks++;
            if ({f.ur, f.data} !== {1'b1, 64'h0})
                $display("FAIL b2b_tail_underrun: got ur=%b data=%h expected ur=1 data=0", f.ur, f.data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit     ok_1, ok_2, ok, hit;
        int     acc;
        frame_t f;
        do_reset(3);
        send_pair(24'h111111, 24'h222222, 20, ok_1, acc);
        send_pair(24'h333333, 24'h444444, 600, ok_2, acc);
        @(negedge clk);
        sample_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (mon_bit == 40) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!(ok_1 && ok_2 && hit && sample_ready === 1'b0))
            $display("FAIL mid_setup: got ok1=%0d ok2=%0d at40=%0d ready=%b expected 1 1 1 0",
                     ok_1, ok_2, hit, sample_ready);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001)
            $display("FAIL mid_reset_values: got %b expected 00001", {bclk, lrclk, sdata, underrun, sample_ready});
        else n_pass++;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        wait_frames(1, ok);
        n_checks++;
        if (!ok) $display("FAIL mid_frames_timeout: got %0d frames expected 1", obs_q.size());
        else n_pass++;
        if (ok) begin
            f = obs_q.pop_front();
            n_checks++;
            if ({f.ur, f.data} !== {1'b1, 64'h0})
                $display("FAIL mid_after_reset: got ur=%b data=%h expected ur=1 data=0", f.ur, f.data);
            else n_pass++;
            n_checks++;
            if (mon_ur_total != 1) $display("FAIL mid_ur_count: got %0d expected 1", mon_ur_total);
            else n_pass++;
        end
    endtask

    task automatic test_param_corner();
        logic [47:0] got_d, got_lr, exp_d, exp_lr;
        int          toggles, nb, ur_cyc;
        logic        prev;
        got_d   = '0;
        got_lr  = '0;
        exp_d   = {24'h800001, 24'h7FFFFE};
        for (int b = 0; b < 48; b++) exp_lr[47-b] = (b >= 23 && b <= 46);
        toggles = 0;
        nb      = 0;
        ur_cyc  = -1;
        @(negedge clk);
        rst_b   = 1'b1;
        left_b  = 24'h800001;
        right_b = 24'h7FFFFE;
        valid_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        valid_b = 1'b0;
        n_checks++;
        if ({bclk_b, ready_b} !== 2'b10) $display("FAIL corner_first_edge: got bclk,ready=%b expected 10", {bclk_b, ready_b});
        else n_pass++;
        prev = bclk_b;
        for (int k = 2; k <= 98; k++) begin
            @(negedge clk);
            if (bclk_b !== prev) toggles++;
            if (prev === 1'b1 && bclk_b === 1'b0) begin
                if (nb < 48) begin
                    got_d[47-nb]  = sdata_b;
                    got_lr[47-nb] = lrclk_b;
                end
                nb++;
            end
            if (underrun_b === 1'b1 && ur_cyc < 0) ur_cyc = k;
            prev = bclk_b;
        end
        n_checks++;
        if (toggles != 97 || nb != 49) $display("FAIL corner_bclk: got toggles=%0d falls=%0d expected 97 49", toggles, nb);
        else n_pass++;
        n_checks++;
        if (got_d !== exp_d) $display("FAIL corner_data: got %h expected %h", got_d, exp_d);
        else n_pass++;
        n_checks++;
        if (got_lr !== exp_lr) $display("FAIL corner_lrclk: got %h expected %h", got_lr, exp_lr);
        else n_pass++;
        n_checks++;
        if (ur_cyc != 98) $display("FAIL corner_frame_period: got underrun at %0d expected 98", ur_cyc);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        sample_left  = '0;
        sample_right = '0;
        sample_valid = 1'b0;
        rst_b        = 1'b1;
        left_b       = '0;
        right_b      = '0;
        valid_b      = 1'b0;
        test_reset();
        test_single_pair();
        test_underrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_param_corner();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
